uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Host-command front end between the UART receiver/transmitter and the internal 8-bit register bus. It parses framed host commands (single write, single read, incrementing burst read, fixed-address stream read) from the RX byte stream and issues register-bus cycles. It returns read data or acknowledge bytes through the TX byte interface. The stream read is the path that drains captured camera frame data through one fixed register address.

## Interface
- CMD_WR, 8'h01: single write command code
- CMD_RD, 8'h02: single read command code
- CMD_BRI, 8'h03: burst read, incrementing address
- CMD_BRS, 8'h04: burst read, fixed address (stream)
- ACK_BYTE, 8'hAA: response to a completed write
- NAK_BYTE, 8'hEE: response to an unknown command code
- TIMEOUT_CYC, 100000: inter-byte timeout in clock cycles (used only with the timeout feature)

Ports:
- xipMCLK, in, 1: system clock
- xipRESET, in, 1: asynchronous, active-high reset
- rx_data, in, 8: received byte
- rx_valid, in, 1: one-cycle strobe, rx_data valid
- tx_data, out, 8: byte to transmit
- tx_valid, out, 1: tx_data valid; held until accepted
- tx_ready, in, 1: transmitter accepts the byte when tx_valid & tx_ready
- reg_addr, out, 8: register address
- reg_wdata, out, 8: write data
- reg_we, out, 1: one-cycle write strobe
- reg_re, out, 1: one-cycle read strobe
- reg_rdata, in, 8: read data, valid exactly one cycle after reg_re
- busy, out, 1: high whenever the state is not IDLE
- overrun, out, 1: sticky; a byte arrived while the parser could not accept it

## Operation
- Frame formats:
  - Write: CMD_WR, ADDR, DATA.
  - Read: CMD_RD, ADDR.
  - Burst read (CMD_BRI or CMD_BRS): CMD, ADDR, CNT. The burst performs CNT+1 reads (CNT=8'hC7 gives 200 reads).
- States: IDLE, GET_ADDR, GET_ARG, BUS_WR, BUS_RD, CAPTURE, SEND.
- IDLE, rx byte received:
  - Known code: latch the command and go to GET_ADDR.
  - Unknown code: load NAK_BYTE and go to SEND; after the send, return to IDLE.
- GET_ADDR, rx byte received: latch the address.
  - CMD_RD: go to BUS_RD.
  - Other commands: go to GET_ARG.
- GET_ARG, rx byte received:
  - CMD_WR: latch the data and go to BUS_WR.
  - Burst commands: latch the count and go to BUS_RD.
- BUS_WR: pulse reg_we, load ACK_BYTE and go to SEND.
- BUS_RD: pulse reg_re, then go to CAPTURE.
- CAPTURE: register reg_rdata into tx_data, assert tx_valid and go to SEND.
- SEND: hold tx_valid and tx_data until tx_ready. On the handshake:
  - If burst reads remain: decrement the remaining count and go to BUS_RD. For CMD_BRI, reg_addr increments mod 256 (8'hFF wraps to 8'h00). For CMD_BRS, reg_addr is unchanged.
  - Otherwise go to IDLE.
- Only one read is outstanding at a time; there is no prefetch.
- rx_valid in BUS_*, CAPTURE or SEND: the byte is discarded and overrun is set. overrun clears only on reset.
- reg_addr and reg_wdata hold their last values between cycles.

## Timing
- Reset values: tx_data=0, tx_valid=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, overrun=0. The state is IDLE.
- Let the final frame byte be accepted in cycle N.
  - Write: reg_we high in N+1; tx_valid high from N+2.
  - Read: reg_re high in N+1; reg_rdata sampled in N+2; tx_valid high from N+3.
- Burst: if the handshake occurs in cycle M, the next reg_re is in M+1 and the next tx_valid is from M+3.
- tx_valid never drops without a handshake, except on reset.
- rx_valid in the same cycle as a tx handshake while in SEND: the byte is discarded and overrun is set, because the state is still SEND.
- Reset mid-frame or mid-burst: asynchronous return to IDLE. All outputs take their reset values, and any partial frame is lost.

## Configuration
- UART_CMD_TIMEOUT_EN defined:
  - A counter clears on every accepted rx byte and counts while in GET_ADDR or GET_ARG.
  - At TIMEOUT_CYC the parser returns to IDLE silently and discards the partial frame.
  - The counter is inactive in other states.
- UART_CMD_TIMEOUT_EN undefined: no counter exists; a partial frame waits indefinitely.

## Structure
- Shared defines header uart_cmd_defs.vh holds:
  - command codes
  - ACK/NAK bytes
  - state encodings (3 bits)
- Sub-module uart_cmd_timer: the inter-byte timeout counter, instantiated only under UART_CMD_TIMEOUT_EN. Its ports are clear, enable and expired.

## Test plan
- Write 01,90,0A with a register model attached: reg_we one cycle with addr 90 and wdata 0A; then tx byte AA.
- Read 02,80 with the model returning 5C: reg_re in N+1; tx byte 5C from N+3.
- Burst 03,FE,03 with model data = address: reads at FE,FF,00,01 (wrap); tx bytes FE,FF,00,01 in order. Hold tx_ready low for 10 cycles mid-burst: tx_valid and tx_data stay stable.
- Stream 04,00,C7: exactly 200 reg_re pulses, all at addr 00; 200 tx bytes; busy falls after the last handshake.
- Unknown code 7F: tx byte EE and return to IDLE. A byte injected during SEND sets overrun, and overrun stays set.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYC=50: send 02 and wait 60 cycles, then send 02,81 → exactly one read, at address 81. Separately, assert reset during a burst: all outputs take their reset values.

Source files
------------

// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser_pkg: command codes, response bytes, FSM states and defaults shared by the parser and its timer
package uart_cmd_parser_pkg;
  localparam logic [7:0] CMD_WR   = 8'h01;
  localparam logic [7:0] CMD_RD   = 8'h02;
  localparam logic [7:0] CMD_BRI  = 8'h03;
  localparam logic [7:0] CMD_BRS  = 8'h04;
  localparam logic [7:0] ACK_BYTE = 8'hAA;
  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam int TIMEOUT_CYC_DEF  = 100000;
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_ARG, BUS_WR, BUS_RD, CAPTURE, SEND} state_t;
  function automatic logic is_known(input logic [7:0] c);
    return c inside {CMD_WR, CMD_RD, CMD_BRI, CMD_BRS};
  endfunction
endpackage

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte timeout counter
// Ports: xipMCLK/xipRESET clock and async reset; clear restarts the count;
// enable lets it count; expired is high once TIMEOUT_CYC idle cycles have elapsed.
module uart_cmd_timer
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic xipMCLK,
  input  logic xipRESET,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1);
  logic [W-1:0] r_cnt;
  assign expired = r_cnt == W'(TIMEOUT_CYC);
  always_ff @(posedge xipMCLK or posedge xipRESET) begin
    if (xipRESET) r_cnt <= '0;
    else if (clear || !enable) r_cnt <= '0;
    else if (!expired) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser: parses host command frames from the UART RX stream into register-bus cycles and TX responses
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       xipMCLK,
  input  logic       xipRESET,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic       busy,
  output logic       overrun
);
  state_t     r_state, w_next;
  logic [7:0] r_cmd, r_cnt, r_addr, r_wdata, r_tx_data;
  logic       r_overrun, w_tmo, w_get;
  assign w_get = r_state inside {GET_ADDR, GET_ARG};
`ifdef UART_CMD_TIMEOUT_EN
  uart_cmd_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .xipMCLK (xipMCLK),
    .xipRESET(xipRESET),
    .clear   (rx_valid),
    .enable  (w_get),
    .expired (w_tmo)
  );
`else
  assign w_tmo = 1'b0;
`endif
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_state == SEND;
  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_state == BUS_WR;
  assign reg_re    = r_state == BUS_RD;
  assign busy      = r_state != IDLE;
  assign overrun   = r_overrun;
  always_ff @(posedge xipMCLK or posedge xipRESET) begin
    if (xipRESET) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (rx_valid) w_next = is_known(rx_data) ? GET_ADDR : SEND;
      GET_ADDR: w_next = rx_valid ? (r_cmd == CMD_RD ? BUS_RD : GET_ARG) : (w_tmo ? IDLE : GET_ADDR);
      GET_ARG:  w_next = rx_valid ? (r_cmd == CMD_WR ? BUS_WR : BUS_RD) : (w_tmo ? IDLE : GET_ARG);
      BUS_WR:   w_next = SEND;
      BUS_RD:   w_next = CAPTURE;
      CAPTURE:  w_next = SEND;
      SEND:     if (tx_ready) w_next = r_cnt != 8'd0 ? BUS_RD : IDLE;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge xipMCLK or posedge xipRESET) begin
    if (xipRESET) begin
      r_cmd     <= '0;
      r_cnt     <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_tx_data <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (rx_valid && !(r_state == IDLE || w_get)) r_overrun <= 1'b1;
      case (r_state)
        IDLE: if (rx_valid) begin
          r_cmd <= rx_data;
          r_cnt <= '0;
          if (!is_known(rx_data)) r_tx_data <= NAK_BYTE;
        end
        GET_ADDR: if (rx_valid) r_addr <= rx_data;
        GET_ARG: if (rx_valid) begin
          if (r_cmd == CMD_WR) r_wdata <= rx_data;
          else r_cnt <= rx_data;
        end
        BUS_WR:  r_tx_data <= ACK_BYTE;
        CAPTURE: r_tx_data <= reg_rdata;
        SEND: if (tx_ready && r_cnt != 8'd0) begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cmd == CMD_BRI) r_addr <= r_addr + 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser: directed and randomized frames against a frame-level reference model
module tb_uart_cmd_parser;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] rx_data = '0, tx_data, reg_addr, reg_wdata, reg_rdata;
  logic rx_valid = 1'b0, tx_valid, tx_ready, reg_we, reg_re, busy, overrun;
  logic rnd_mode = 1'b0, rnd_bit = 1'b1, rdy_val = 1'b1;
  logic [7:0] pat = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(negedge clk) rnd_bit = $urandom_range(0, 3) != 0;
  assign tx_ready = rnd_mode ? rnd_bit : rdy_val;
  uart_cmd_parser #(.TIMEOUT_CYC(50)) dut (
    .xipMCLK(clk), .xipRESET(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .busy(busy), .overrun(overrun)
  );
  logic       wr_f[256];
  logic [7:0] wr_d[256];
  always @(posedge clk) begin
    if (rst) for (int i = 0; i < 256; i++) wr_f[i] <= 1'b0;
    else if (reg_we) begin
      wr_f[reg_addr] <= 1'b1;
      wr_d[reg_addr] <= reg_wdata;
    end
    reg_rdata <= wr_f[reg_addr] ? wr_d[reg_addr] : reg_addr ^ pat;
  end
  logic [16:0] busq[$], exp_bus[$];
  logic [7:0]  txq[$], exp_tx[$];
  always @(posedge clk) if (!rst) begin
    if (reg_we) busq.push_back({1'b1, reg_addr, reg_wdata});
    if (reg_re) busq.push_back({1'b0, reg_addr, 8'h00});
    if (tx_valid && tx_ready) txq.push_back(tx_data);
  end
  logic       ref_f[256];
  logic [7:0] ref_d[256];
  function automatic logic [7:0] ref_rd(input logic [7:0] a);
    return ref_f[a] ? ref_d[a] : a ^ pat;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask
  task automatic check_frames(input string tag);
    chk({tag, "_txcount"}, txq.size(), exp_tx.size());
    for (int i = 0; i < txq.size() && i < exp_tx.size(); i++) chk({tag, "_tx"}, txq[i], exp_tx[i]);
    chk({tag, "_buscount"}, busq.size(), exp_bus.size());
    for (int i = 0; i < busq.size() && i < exp_bus.size(); i++) chk({tag, "_bus"}, busq[i], exp_bus[i]);
    txq.delete(); busq.delete(); exp_tx.delete(); exp_bus.delete();
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_reg_addr"}, reg_addr, 0);
    chk({tag, "_reg_wdata"}, reg_wdata, 0);
    chk({tag, "_reg_we"}, reg_we, 0);
    chk({tag, "_reg_re"}, reg_re, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_overrun"}, overrun, 0);
  endtask
  initial begin
    logic [7:0] fr[$];
    logic [7:0] a, d, c, aa;
    int k, n;
    for (int i = 0; i < 256; i++) ref_f[i] = 1'b0;
    cycles(3);
    check_reset_outputs("reset");
    rst = 1'b0;
    rdy_val = 1'b0;
    send(8'h01); send(8'h90); send(8'h0A);
    chk("wr_we", reg_we, 1);
    chk("wr_addr", reg_addr, 8'h90);
    chk("wr_wdata", reg_wdata, 8'h0A);
    chk("wr_txv_early", tx_valid, 0);
    cycles(1);
    chk("wr_we_single", reg_we, 0);
    chk("wr_txv", tx_valid, 1);
    chk("wr_ack", tx_data, 8'hAA);
    rdy_val = 1'b1;
    wait_idle(20);
    ref_f[8'h90] = 1'b1; ref_d[8'h90] = 8'h0A;
    exp_bus.push_back({1'b1, 8'h90, 8'h0A}); exp_tx.push_back(8'hAA);
    check_frames("wr");
    pat = 8'hDC;
    rdy_val = 1'b0;
    send(8'h02); send(8'h80);
    chk("rd_re", reg_re, 1);
    chk("rd_addr", reg_addr, 8'h80);
    cycles(1);
    chk("rd_txv_n2", tx_valid, 0);
    cycles(1);
    chk("rd_txv_n3", tx_valid, 1);
    chk("rd_data", tx_data, 8'h5C);
    rdy_val = 1'b1;
    wait_idle(20);
    exp_bus.push_back({1'b0, 8'h80, 8'h00}); exp_tx.push_back(8'h5C);
    check_frames("rd");
    pat = 8'h00;
    send(8'h03); send(8'hFE); send(8'h03);
    n = 0;
    while (txq.size() < 2 && n < 200) begin @(negedge clk); n++; end
    rdy_val = 1'b0;
    chk("bri_progress", txq.size(), 2);
    n = 0;
    while (!tx_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("bri_stall_valid", tx_valid, 1);
      chk("bri_stall_data", tx_data, 8'h00);
      cycles(1);
    end
    rdy_val = 1'b1;
    wait_idle(50);
    for (int i = 0; i < 4; i++) begin
      aa = 8'hFE + 8'(i);
      exp_bus.push_back({1'b0, aa, 8'h00});
      exp_tx.push_back(ref_rd(aa));
    end
    check_frames("bri");
    pat = 8'($urandom);
    rnd_mode = 1'b1;
    send(8'h04); send(8'h00); send(8'hC7);
    wait_idle(5000);
    for (int i = 0; i < 200; i++) begin
      exp_bus.push_back({1'b0, 8'h00, 8'h00});
      exp_tx.push_back(ref_rd(8'h00));
    end
    check_frames("brs");
    rnd_mode = 1'b0;
    rdy_val = 1'b0;
    send(8'h7F);
    chk("nak_valid", tx_valid, 1);
    chk("nak_data", tx_data, 8'hEE);
    chk("nak_overrun_clear", overrun, 0);
    send(8'h55);
    chk("ovr_set", overrun, 1);
    chk("ovr_busy", busy, 1);
    rdy_val = 1'b1;
    wait_idle(20);
    chk("ovr_sticky", overrun, 1);
    exp_tx.push_back(8'hEE);
    check_frames("nak");
    rnd_mode = 1'b1;
    pat = 8'($urandom);
    for (int f = 0; f < 30; f++) begin
      k = $urandom_range(0, 4);
      a = 8'($urandom); d = 8'($urandom); c = 8'($urandom_range(0, 7));
      fr.delete();
      case (k)
        0: begin
          fr = '{8'h01, a, d};
          exp_bus.push_back({1'b1, a, d}); exp_tx.push_back(8'hAA);
          ref_f[a] = 1'b1; ref_d[a] = d;
        end
        1: begin
          fr = '{8'h02, a};
          exp_bus.push_back({1'b0, a, 8'h00}); exp_tx.push_back(ref_rd(a));
        end
        2, 3: begin
          fr = '{(k == 2) ? 8'h03 : 8'h04, a, c};
          for (int i = 0; i <= int'(c); i++) begin
            aa = (k == 2) ? a + 8'(i) : a;
            exp_bus.push_back({1'b0, aa, 8'h00}); exp_tx.push_back(ref_rd(aa));
          end
        end
        default: begin
          fr = '{8'($urandom_range(5, 255))};
          exp_tx.push_back(8'hEE);
        end
      endcase
      foreach (fr[i]) begin
        send(fr[i]);
        cycles($urandom_range(0, 3));
      end
      wait_idle(2000);
      check_frames("rand");
    end
`ifdef UART_CMD_TIMEOUT_EN
    rnd_mode = 1'b0;
    rdy_val = 1'b1;
    send(8'h02);
    cycles(60);
    chk("tmo_idle", busy, 0);
    send(8'h02); send(8'h81);
    wait_idle(20);
    exp_bus.push_back({1'b0, 8'h81, 8'h00}); exp_tx.push_back(ref_rd(8'h81));
    check_frames("tmo");
`endif
    rnd_mode = 1'b0;
    rdy_val = 1'b1;
    send(8'h03); send(8'h10); send(8'hFF);
    cycles(20);
    chk("mid_burst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    cycles(2);
    check_reset_outputs("held_rst");
    rst = 1'b0;
    cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
